// File: rtl/fft_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg
// Shared types and constants for the radix-2 FFT butterfly scheduler.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fft_pkg;

  // Default sample address width; a transform has at most 2^FFT_ADDR_W points.
  localparam int FFT_ADDR_W = 11;

  // Largest accepted log2 of the point count.
  localparam int MAX_LOG2N = FFT_ADDR_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } sched_state_t;

endpackage

`default_nettype wire

// File: rtl/fft_bfly_addr.sv
// ---------------------------------------------------------------------------
// fft_bfly_addr
// Combinational butterfly descriptor mapping: (j, s, L) -> (A, B, twiddle).
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fft_bfly_addr
  import fft_pkg::*;
#(
  parameter int ADDR_W = FFT_ADDR_W
) (
  input  logic [ADDR_W-2:0] j_i,
  input  logic [3:0]        s_i,
  input  logic [3:0]        l_i,
  output logic [ADDR_W-1:0] addr_a_o,
  output logic [ADDR_W-1:0] addr_b_o,
  output logic [ADDR_W-2:0] tw_idx_o
);

  localparam logic [ADDR_W-2:0] K_ONE = (ADDR_W-1)'(1);

  logic [ADDR_W-1:0] half_w;
  logic [ADDR_W-2:0] k_w;
  logic [ADDR_W-1:0] a_w;
  logic [3:0]        tw_sh_w;

  // Butterfly j of stage s: split j at bit s and open a gap of width 'half'.
  // k is always below 2^(L-1), so it fits the twiddle width; when s is the
  // top stage the truncated half-1 becomes all ones, which is exactly k=j.
  always_comb begin
    half_w   = ADDR_W'(1) << s_i;
    k_w      = j_i & (half_w[ADDR_W-2:0] - K_ONE);
    a_w      = (({1'b0, j_i} >> s_i) << (s_i + 4'd1)) | {1'b0, k_w};
    tw_sh_w  = l_i - 4'd1 - s_i;
    addr_a_o = a_w;
    addr_b_o = a_w | half_w;
    tw_idx_o = k_w << tw_sh_w;
  end

endmodule

`default_nettype wire

// File: rtl/fft_bfly_sched.sv
// ---------------------------------------------------------------------------
// fft_bfly_sched
// Radix-2 in-place FFT butterfly scheduler: issues descriptors stage by stage
// with a valid/ready handshake and drains the datapath between stages.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fft_bfly_sched
  import fft_pkg::*;
#(
  parameter int ADDR_W    = FFT_ADDR_W,
  parameter int MAX_LOG2N = ADDR_W
) (
  input  logic              clk,
  input  logic              n_Reset,
  input  logic              START,
  input  logic [3:0]        LOG2N,
  output logic              BF_VALID,
  input  logic              BF_READY,
  output logic [ADDR_W-1:0] ADDR_A,
  output logic [ADDR_W-1:0] ADDR_B,
  output logic [ADDR_W-2:0] TW_IDX,
  output logic [3:0]        STAGE,
  input  logic              DP_IDLE,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR
);

  localparam logic [3:0]        MAX_L = 4'(MAX_LOG2N);
  localparam logic [ADDR_W-2:0] J_ONE = (ADDR_W-1)'(1);

  sched_state_t      state_q, state_d;
  logic [ADDR_W-2:0] j_q, j_d;
  logic [3:0]        s_q, s_d;
  logic [3:0]        l_q, l_d;
  logic              err_q, err_d;

  logic [ADDR_W-1:0] addr_a_q, addr_b_q;
  logic [ADDR_W-2:0] tw_q;
  logic [ADDR_W-1:0] addr_a_w, addr_b_w;
  logic [ADDR_W-2:0] tw_w;

  logic [ADDR_W-1:0] last_j_w;
  logic              last_w;

  // Final butterfly index of a stage is N/2-1 = 2^(L-1)-1.
  assign last_j_w = (ADDR_W'(1) << (l_q - 4'd1)) - ADDR_W'(1);
  assign last_w   = ({1'b0, j_q} == last_j_w);

  // The mapper looks at next-state counters so descriptors can be registered
  // and still appear in the first ISSUE cycle.
  fft_bfly_addr #(
    .ADDR_W (ADDR_W)
  ) u_addr (
    .j_i      (j_d),
    .s_i      (s_d),
    .l_i      (l_d),
    .addr_a_o (addr_a_w),
    .addr_b_o (addr_b_w),
    .tw_idx_o (tw_w)
  );

  // Next-state logic: accept/reject START, step j on handshakes, drain between stages.
  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    s_d     = s_q;
    l_d     = l_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (START) begin
          if ((LOG2N != 4'd0) && (LOG2N <= MAX_L)) begin
            l_d     = LOG2N;
            s_d     = 4'd0;
            j_d     = '0;
            state_d = ISSUE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (BF_READY) begin
          if (last_w) begin
            state_d = DRAIN;
          end else begin
            j_d = j_q + J_ONE;
          end
        end
      end
      DRAIN: begin
        // Next stage reads what this one wrote, so wait for writebacks.
        if (DP_IDLE) begin
          if (s_q < (l_q - 4'd1)) begin
            s_d     = s_q + 4'd1;
            j_d     = '0;
            state_d = ISSUE;
          end else begin
            state_d = FINISH;
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge n_Reset) begin
    if (!n_Reset) begin
      state_q <= IDLE;
      j_q     <= '0;
      s_q     <= 4'd0;
      l_q     <= 4'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      s_q     <= s_d;
      l_q     <= l_d;
      err_q   <= err_d;
    end
  end

  // Descriptor registers; they only reload when the next cycle issues.
  always_ff @(posedge clk or negedge n_Reset) begin
    if (!n_Reset) begin
      addr_a_q <= '0;
      addr_b_q <= '0;
      tw_q     <= '0;
    end else if (state_d == ISSUE) begin
      addr_a_q <= addr_a_w;
      addr_b_q <= addr_b_w;
      tw_q     <= tw_w;
    end
  end

  assign BF_VALID = (state_q == ISSUE);
  assign BUSY     = (state_q != IDLE);
  assign DONE     = (state_q == FINISH);
  assign ERR      = err_q;
  assign ADDR_A   = addr_a_q;
  assign ADDR_B   = addr_b_q;
  assign TW_IDX   = tw_q;
  assign STAGE    = s_q;

endmodule

`default_nettype wire

// File: doc/fft_bfly_sched.md
FFT_BFLY_SCHED -- requirements
Module: fft_bfly_sched

Interface
REQ-001 Parameter: ADDR_W, 11, sample address width; the maximum transform is 2^ADDR_W points.
REQ-002 Parameter: MAX_LOG2N, ADDR_W, largest accepted LOG2N.
REQ-003 Port: clk  in  1  single clock; all state changes on its rising edge.
REQ-004 Port: n_Reset  in  1  reset; asynchronous, active-low.
REQ-005 Port: START  in  1  request one transform; sampled only in IDLE.
REQ-006 Port: LOG2N  in  4  log2 of point count; captured when START is accepted.
REQ-007 Port: BF_VALID  out  1  butterfly descriptor valid.
REQ-008 Port: BF_READY  in  1  datapath accepts the descriptor.
REQ-009 Port: ADDR_A  out  ADDR_W  upper butterfly input/output address.
REQ-010 Port: ADDR_B  out  ADDR_W  lower butterfly input/output address.
REQ-011 Port: TW_IDX  out  ADDR_W-1  twiddle ROM index.
REQ-012 Port: STAGE  out  4  current stage number s.
REQ-013 Port: DP_IDLE  in  1  datapath pipeline empty, with all writebacks complete.
REQ-014 Port: BUSY  out  1  high in every state except IDLE.
REQ-015 Port: DONE  out  1  one-cycle pulse when the transform is complete.
REQ-016 Port: ERR  out  1  one-cycle pulse when START is rejected.

Function
REQ-017 FSM states: IDLE, ISSUE, DRAIN, FINISH.
REQ-018 IDLE, START=1, 1<=LOG2N<=MAX_LOG2N:
  - capture L=LOG2N;
  - clear s and j;
  - go to ISSUE.
REQ-019 IDLE, START=1, LOG2N=0 or LOG2N>MAX_LOG2N: ERR=1 for one cycle; remain in IDLE.
REQ-020 START outside IDLE is ignored, with no ERR.
REQ-021 In ISSUE, BF_VALID=1.
REQ-022 First BF_VALID occurs the cycle after START is accepted.
REQ-023 Descriptor for butterfly counter j (0..N/2-1) in stage s, with half=2^s and k=j&(half-1):
  - ADDR_A = ((j>>s)<<(s+1)) | k;
  - ADDR_B = ADDR_A | half;
  - TW_IDX = k << (L-1-s).
REQ-024 All arithmetic is unsigned; results are truncated to port widths with no overflow for L<=MAX_LOG2N.
REQ-025 While BF_VALID=1 and BF_READY=0:
  - ADDR_A, ADDR_B, TW_IDX and STAGE hold stable;
  - BF_VALID stays 1.
REQ-026 A handshake (BF_VALID & BF_READY) advances j by 1.
REQ-027 Back-to-back handshakes give one butterfly per cycle.
REQ-028 Handshake with j = N/2-1: go to DRAIN; BF_VALID=0 from the next cycle.
REQ-029 In DRAIN, wait for DP_IDLE=1 (read-after-write hazard across stages). Then:
  - if s<L-1: s+=1, j=0, return to ISSUE;
  - else go to FINISH.
REQ-030 DP_IDLE=1 already on DRAIN entry still requires one cycle in DRAIN (minimum one-cycle inter-stage gap).
REQ-031 FINISH lasts one cycle: DONE=1, then go to IDLE.
REQ-032 In IDLE and FINISH, BF_VALID=0.
REQ-033 BF_READY is ignored when BF_VALID=0.
REQ-034 LOG2N changes after capture have no effect until the next accepted START.
REQ-035 Per transform:
  - total handshakes = L*2^(L-1);
  - stages issued in ascending s;
  - j ascending within each stage.

Reset
REQ-036 n_Reset=0 immediately forces state IDLE and s=j=L=0.
REQ-037 During reset: BF_VALID=BUSY=DONE=ERR=0; ADDR_A=ADDR_B=TW_IDX=STAGE=0.
REQ-038 Reset asserted mid-transform aborts it with no DONE pulse; the next START begins from s=0, j=0.

Structure
REQ-039 Package fft_pkg holds:
  - sched_state_t enum (IDLE, ISSUE, DRAIN, FINISH);
  - constants MAX_LOG2N and FFT_ADDR_W.
REQ-040 Sub-module fft_bfly_addr: purely combinational (j, s, L) -> (ADDR_A, ADDR_B, TW_IDX) mapping, instantiated once.
REQ-041 Descriptor outputs are registered; no combinational path from BF_READY to any output.

Verification
REQ-042 LOG2N=3, BF_READY=1, DP_IDLE=1 -> exactly 12 descriptors, then one DONE:
  - s0: (0,1),(2,3),(4,5),(6,7), TW all 0;
  - s1: (0,2),(1,3),(4,6),(5,7), TW 0,2,0,2;
  - s2: (0,4),(1,5),(2,6),(3,7), TW 0,1,2,3.
REQ-043 LOG2N=2 with BF_READY toggling 1,0,0,1,... -> descriptors held stable during stalls; sequence (0,1),(2,3),(0,2),(1,3), TW 0,0,0,1.
REQ-044 LOG2N=3, DP_IDLE held 0 for 5 cycles after stage-0 completion -> no BF_VALID in those cycles; stage 1 starts the cycle after DP_IDLE rises.
REQ-045 START with LOG2N=0 and with LOG2N=12 -> one ERR pulse each, BUSY stays 0; START during ISSUE -> ignored.
REQ-046 LOG2N=4, n_Reset pulsed low at handshake 10 -> all outputs 0 at once, no DONE; a new START gives the first descriptor (0,1), TW 0.
